// File: rtl/crc_engine_if.sv
// Stream-side bundle for crc_engine: framed word input plus registered CRC results.
interface crc_engine_if #(
   parameter int unsigned CRC_W  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 16
) ();
   logic              start;
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              data_last;
   logic              data_ready;
   logic [CRC_W-1:0]  check_in;
   logic [CRC_W-1:0]  crc_out;
   logic              crc_valid;
   logic              crc_match;
   logic [LEN_W-1:0]  word_count;
   logic              busy;

   modport master (
      output start, data_in, data_valid, data_last, check_in,
      input  data_ready, crc_out, crc_valid, crc_match, word_count, busy
   );

   modport slave (
      input  start, data_in, data_valid, data_last, check_in,
      output data_ready, crc_out, crc_valid, crc_match, word_count, busy
   );
endinterface

// File: rtl/crc_engine.sv
// Parametrised frame CRC generator/checker: processes DATA_W bits per accepted word,
// registers the final CRC, word count and compare result on the last word.
module crc_engine #(
   parameter int unsigned      CRC_W       = 8,
   parameter logic [CRC_W-1:0] POLY        = 8'h07,
   parameter logic [CRC_W-1:0] INIT        = '0,
   parameter logic [CRC_W-1:0] XOR_OUT     = '0,
   parameter bit               REFLECT_IN  = 1'b0,
   parameter bit               REFLECT_OUT = 1'b0,
   parameter int unsigned      DATA_W      = 8,
   parameter int unsigned      LEN_W       = 16
) (
   input  logic         clk,
   input  logic         reset,
   crc_engine_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CRC_W-1:0]  crc_q, crc_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [CRC_W-1:0]  crc_out_q, crc_out_d;
   logic              match_q, match_d;
   logic [LEN_W-1:0]  wc_q, wc_d;

   logic [CRC_W-1:0]  crc_next;
   logic [CRC_W-1:0]  crc_final;
   logic [LEN_W-1:0]  cnt_inc;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] c);
      logic [CRC_W-1:0] r;
      for (int i = 0; i < int'(CRC_W); i++) r[i] = c[int'(CRC_W)-1-i];
      return r;
   endfunction

   // Byte lanes go most-significant first; within a byte, MSB first after optional reflection.
   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                 input logic [DATA_W-1:0] w);
      logic [CRC_W-1:0] r;
      logic [7:0]       b;
      logic             fb;
      r = c;
      for (int l = int'(DATA_W / 8) - 1; l >= 0; l--) begin
         b = w[8*l +: 8];
         if (REFLECT_IN) b = rev8(b);
         for (int i = 7; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ b[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
         end
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      state_d   = state_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      crc_out_d = crc_out_q;
      match_d   = match_q;
      wc_d      = wc_q;

      crc_next  = crc_step(crc_q, bus.data_in);
      crc_final = (REFLECT_OUT ? rev_crc(crc_next) : crc_next) ^ XOR_OUT;
      cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);

      if (bus.start) begin
         state_d = S_RUN;
         crc_d   = INIT;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_RUN: begin
               if (bus.data_valid) begin
                  crc_d = crc_next;
                  cnt_d = cnt_inc;
                  if (bus.data_last) begin
                     state_d   = S_DONE;
                     crc_out_d = crc_final;
                     match_d   = (crc_final == bus.check_in);
                     wc_d      = cnt_inc;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         crc_q     <= INIT;
         cnt_q     <= '0;
         crc_out_q <= '0;
         match_q   <= 1'b0;
         wc_q      <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         cnt_q     <= cnt_d;
         crc_out_q <= crc_out_d;
         match_q   <= match_d;
         wc_q      <= wc_d;
      end
   end

   // Handshake outputs decode the state register only.
   assign bus.data_ready = (state_q == S_RUN);
   assign bus.busy       = (state_q == S_RUN);
   assign bus.crc_valid  = (state_q == S_DONE);
   assign bus.crc_out    = crc_out_q;
   assign bus.crc_match  = match_q;
   assign bus.word_count = wc_q;

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised, frame-oriented CRC generator and checker. It supersedes the fixed CRC-8/0x07 byte engine. Width, polynomial, init value, final XOR, bit reflection and data-path width are all configurable. A start/valid/last/ready handshake frames each message. The block sits between the byte/word stream source (UART or packet framer) and the frame-validation logic. It produces a registered final CRC, a frame word count and a pass/fail compare against an expected CRC.

## Interface

- CRC_W, 8: CRC width in bits, 8..32.
- POLY, 8'h07: generator polynomial, normal (MSB-first) form, implicit x^CRC_W term omitted.
- INIT, 0: CRC register value loaded at frame start.
- XOR_OUT, 0: value XORed into the register to form the final CRC.
- REFLECT_IN, 0: 1 = bit-reverse each input byte before processing.
- REFLECT_OUT, 0: 1 = bit-reverse the full CRC_W register before XOR_OUT.
- DATA_W, 8: input word width; must be a multiple of 8, range 8..64.
- LEN_W, 16: width of the frame word counter.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new frame (synchronous init); honoured in any state.
- data_in  in  DATA_W  message word; byte lanes processed from [DATA_W-1:DATA_W-8] down to [7:0].
- data_valid  in  1  data_in holds a valid word.
- data_last  in  1  qualifies the current valid word as the final word of the frame.
- data_ready  out  1  engine accepts a word this cycle.
- check_in  in  CRC_W  expected CRC, sampled on the accepted last word.
- crc_out  out  CRC_W  final CRC of the last completed frame (registered).
- crc_valid  out  1  one-cycle pulse: crc_out, crc_match and word_count are updated.
- crc_match  out  1  1 = final CRC equals check_in.
- word_count  out  LEN_W  number of words accepted in the last completed frame.
- busy  out  1  a frame is in progress (state RUN).

## Operation

- States: IDLE, RUN, DONE.
- reset (takes priority over everything else): state to IDLE, CRC register to INIT. crc_out, crc_match, word_count and the internal counter go to 0. data_ready, crc_valid and busy go to 0.
- start (any state, priority over data): state to RUN, CRC register to INIT, internal counter to 0. Any frame in progress is discarded silently, with no crc_valid. Outputs of the previous completed frame are held.
- IDLE: data_ready = 0. Words are ignored.
- RUN: data_ready = 1. A word is accepted when data_valid & data_ready & !start.
  - The CRC register advances by DATA_W bits: each byte lane in order, each byte MSB-first.
  - When REFLECT_IN = 1, each byte is bit-reversed first.
  - Per bit: fb = reg[CRC_W-1] ^ bit; reg = {reg[CRC_W-2:0],0} ^ (fb ? POLY : 0).
  - Internal counter increments and saturates at 2^LEN_W-1.
- Accepted word with data_last = 1: go to DONE and register the results.
  - crc_out = (REFLECT_OUT ? reverse(reg_next) : reg_next) ^ XOR_OUT.
  - crc_match = (crc_out value == check_in).
  - word_count = counter+1, saturated.
- DONE: crc_valid = 1 for exactly this cycle. Next state is IDLE, or RUN if start is asserted.
- data_last without data_valid has no effect. There are no zero-length frames.

## Timing

- data_ready and busy are decoded from the state register: combinational from state only, with no input-to-output path.
- One word per cycle in RUN. There are no bubbles.
- Last word accepted at edge N: crc_valid is high in cycle N+1 and crc_out/crc_match/word_count are valid from N+1.
- Results hold until the next crc_valid or reset.
- Back-to-back frames: start asserted in the DONE cycle gives data_ready = 1 in cycle N+2. The minimum inter-frame gap is 1 cycle.
- start and data_valid together in RUN: the word is dropped and the frame restarts.
- Reset mid-frame: state returns to IDLE the next cycle. No crc_valid is produced.

## Test plan

- CRC_W=8, POLY=07, INIT=0, DATA_W=8, ASCII "123456789" (9 words, last on '9') -> crc_out=8'hF4, word_count=9, crc_valid single pulse 1 cycle after last.
- CRC_W=16, POLY=1021, INIT=FFFF, no reflect, same message -> 16'h29B1. Same run with check_in=16'h29B1 -> crc_match=1; with check_in=16'h29B0 -> crc_match=0.
- CRC_W=32, POLY=04C11DB7, INIT=XOR_OUT=FFFFFFFF, REFLECT_IN=REFLECT_OUT=1, DATA_W=32, message packed as "1234","5678","9"-padded is not allowed, so use DATA_W=8 -> 32'hCBF43926. DATA_W=32 with message "12345678" (2 words) must match the DATA_W=8 result for the same 8 bytes.
- Abort: start, 4 words, start again, "123456789" -> exactly one crc_valid, crc_out=8'hF4, word_count=9. Previous crc_out is held during the abort.
- Reset mid-frame after 3 words -> next cycle busy=0, data_ready=0, crc_out=0, no crc_valid. The following full frame is computed correctly.
- Back-to-back: frame "\x01" then start in the DONE cycle and frame "\x01\x02" (CRC-8/07) -> crc_out 8'h07 then 8'h1B. crc_valid is separated by 3 cycles.
